// File: rtl/sc_bi_stream_counter_if.sv
// ----------------------------------------------------------------------------
// sc_bi_stream_counter_if
//
// Handshake and data bundle between a bipolar stochastic stream producer and
// the sc_bi_stream_counter block.
//
//   start     producer -> counter  open a conversion window (ignored while busy)
//   in_valid  producer -> counter  bit_in carries a sample this cycle
//   bit_in    producer -> counter  bipolar stream bit (1 -> +1, 0 -> -1)
//   clear     producer -> counter  synchronous abort of the open window
//   busy      counter -> producer  a window is open
//   out_valid counter -> producer  one-cycle pulse, result is fresh
//   result    counter -> producer  signed 2*ones - N, held until next pulse
// ----------------------------------------------------------------------------
interface sc_bi_stream_counter_if #(
  parameter int WIDTH = 8
);
  logic                    start;
  logic                    in_valid;
  logic                    bit_in;
  logic                    clear;
  logic                    busy;
  logic                    out_valid;
  logic signed [WIDTH+1:0] result;

  modport master (
    output start, in_valid, bit_in, clear,
    input  busy, out_valid, result
  );

  modport slave (
    input  start, in_valid, bit_in, clear,
    output busy, out_valid, result
  );
endinterface

// File: rtl/sc_bi_stream_counter.sv
// ----------------------------------------------------------------------------
// sc_bi_stream_counter
//
// Converts a serial bipolar stochastic stream back to a signed binary value.
// A start pulse opens a window of N = 2**WIDTH accepted samples; the number
// of ones is counted and, one cycle after the N-th sample, out_valid pulses
// with result = 2*ones - N (range -N..+N).
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sc_bi_stream_counter_if.slave (start, in_valid, bit_in, clear in;
//          busy, out_valid, result out)
// ----------------------------------------------------------------------------
module sc_bi_stream_counter #(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  sc_bi_stream_counter_if.slave  bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_COUNT = 1'b1;

  // Sample index of the final sample in a window (N-1).
  localparam logic [WIDTH-1:0] CNT_LAST = '1;
  // Window length N expressed in the result width.
  localparam logic [WIDTH+1:0] N_EXT    = (WIDTH+2)'(1) << WIDTH;

  logic [0:0]              state_q, state_d;
  logic [WIDTH:0]          ones_q, ones_d;
  logic [WIDTH-1:0]        cnt_q, cnt_d;
  logic                    out_valid_q, out_valid_d;
  logic signed [WIDTH+1:0] result_q, result_d;

  logic [WIDTH:0]          ones_inc;
  logic [WIDTH+1:0]        ones_x2;

  // Ones count including the sample offered this cycle; the last sample of
  // the window must contribute to the result computed in the same cycle.
  assign ones_inc = ones_q + {{WIDTH{1'b0}}, bus.bit_in};
  assign ones_x2  = {ones_inc, 1'b0};

  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    ones_d      = ones_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    result_d    = result_q;

    if (bus.clear) begin
      // Abort wins over everything; result keeps the last completed value.
      state_d = ST_IDLE;
      ones_d  = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            state_d = ST_COUNT;
            ones_d  = '0;
            cnt_d   = '0;
          end
        end
        ST_COUNT: begin
          if (bus.in_valid) begin
            ones_d = ones_inc;
            if (cnt_q == CNT_LAST) begin
              // Window complete: publish and return to IDLE so a start in
              // the out_valid cycle is honoured.
              cnt_d       = '0;
              out_valid_d = 1'b1;
              result_d    = $signed(ones_x2 - N_EXT);
              state_d     = ST_IDLE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ones_q      <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state_q     <= state_d;
      ones_q      <= ones_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
    end
  end

  assign bus.busy      = (state_q == ST_COUNT);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

endmodule

// File: doc/sc_bi_stream_counter.md
Name: sc_bi_stream_counter

Overview:
- Downstream stage for bipolar stochastic operators such as the XNOR multiplier.
- Consumes one serial bipolar stream bit per valid cycle over a fixed window of N = 2**WIDTH samples.
- Converts the stream back to a signed binary value: result = 2*ones - N, which represents ones/N*2-1 scaled by N.
- Handshake: start pulse opens the window; a single-cycle out_valid pulse closes it.

Parameters:
- WIDTH, 8, log2 of window length; N = 2**WIDTH samples per conversion (WIDTH >= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a conversion window; honoured only when busy=0.
- in_valid  input  1  bit_in is a valid sample this cycle.
- bit_in  input  1  bipolar stochastic stream bit (1 -> +1, 0 -> -1).
- clear  input  1  synchronous abort; returns block to IDLE and discards the partial window.
- busy  output  1  high while a window is open (state COUNT).
- out_valid  output  1  one-cycle pulse; result holds a fresh value.
- result  output  WIDTH+2  signed, 2*ones - N, range [-N, +N]; holds its value until the next out_valid.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: state=IDLE, busy=0, out_valid=0, result=0, ones=0, sample_cnt=0.
- Counter widths:
  - ones: WIDTH+1 bits unsigned, range 0..N.
  - sample_cnt: WIDTH bits.
  - Neither counter wraps within a window.
- IDLE:
  - start=1 -> COUNT next cycle; ones and sample_cnt are cleared.
  - in_valid is ignored.
- COUNT:
  - Each cycle with in_valid=1: ones += bit_in and sample_cnt += 1.
  - in_valid=0 cycles are stalls; counters hold.
  - start is ignored.
  - Accepting the last sample: in_valid=1 with sample_cnt == N-1.
    - The last bit is included in ones.
    - Next cycle: out_valid=1, result = 2*(ones_final) - N, state=IDLE, busy=0.
- Latency: out_valid rises exactly 1 cycle after the N-th accepted sample.
- Back-to-back windows: start may be asserted in the same cycle out_valid=1, because the state is already IDLE. The new window then opens the following cycle.
- Minimum window duration: N+2 cycles from start to out_valid.
- clear:
  - Has priority over start and in_valid.
  - Forces IDLE and zeroes the counters.
  - Does not generate out_valid and does not alter result.
  - clear in IDLE has no effect besides zeroing the counters.
- Reset mid-window: all state returns to reset values immediately; no out_valid is produced.
- Arithmetic for result:
  - Computed as ({1'b0, ones} << 1) - N in WIDTH+2 bits signed.
  - ones = N gives +N.
  - ones = 0 gives -N.
  - ones = N/2 gives 0.
- out_valid is never asserted for two consecutive cycles.

Test Plan:
1. WIDTH=8: start, then 256 valid cycles of bit_in=1 -> out_valid pulse 1 cycle after the last sample, result=+256; busy falls in the same cycle.
2. WIDTH=8: 256 valid cycles of bit_in=0 -> result=-256. Alternating 1/0 stream -> result=0. Stream with 192 ones -> result=+128.
3. WIDTH=4: 16 samples of all ones, interleaved with random in_valid=0 gaps -> result=+16 only after the 16th valid sample; busy stays high through the gaps; no early out_valid.
4. WIDTH=4: start pulses asserted mid-window -> ignored (count unaffected). start asserted on the out_valid cycle -> second window opens; second result is correct and independent of the first.
5. WIDTH=4: clear at sample 7 -> busy=0 next cycle, no out_valid, result retains its previous value. Then rst_n low mid-window -> all outputs 0 asynchronously, before the next clk edge.
6. Feed the XNOR of two independent LFSR streams encoding +0.5 and -0.5 (WIDTH=8) -> result within ±32 of -64 (i.e. -0.25*256).
